dram_256x1_bist_ctrl: RTL and testbench



---
 rtl/dram_256x1_bist_ctrl_if.sv | 24 ++
 rtl/dram_256x1_bist_ctrl.sv | 134 +++++++++++++
 tb/tb_dram_256x1_bist_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_256x1_bist_ctrl_if.sv
// RAM-side bus of the 256x1 BIST sequencer.
// The sequencer is master; the RAM under test is slave.
interface dram_256x1_bist_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_d;
    logic              ram_we;
    logic              ram_q;

    modport master (
        output ram_addr,
        output ram_d,
        output ram_we,
        input  ram_q
    );

    modport slave (
        input  ram_addr,
        input  ram_d,
        input  ram_we,
        output ram_q
    );
endinterface

// File: rtl/dram_256x1_bist_ctrl.sv
// LFSR write/read-back self-test sequencer for a 256x1 async-read RAM.
// Optional inverted second pass: define DRAM_BIST_INV_PASS_EN.
module dram_256x1_bist_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [7:0]             seed,
    dram_256x1_bist_ctrl_if.master ram,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_count,
    output logic [ADDR_W-1:0]      first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DONE  = 3'd3
`ifdef DRAM_BIST_INV_PASS_EN
        ,
        S_WRITE_INV = 3'd4,
        S_READ_INV  = 3'd5
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        lfsr_q, lfsr_nxt;
    logic [7:0]        seed_q, seed_eff;
    logic              done_q;
    logic              wr_st, rd_st, inv;
    logic              last, start_run, pat, mismatch;

    assign last      = (addr_q == {ADDR_W{1'b1}});
    assign start_run = (state_q == S_IDLE) && start;
    assign seed_eff  = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_nxt  = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    assign pat       = lfsr_q[0] ^ inv;
    assign mismatch  = rd_st && (ram.ram_q != pat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (start) state_d = S_WRITE;
            S_WRITE:     if (last) state_d = S_READ;
`ifdef DRAM_BIST_INV_PASS_EN
            S_READ:      if (last) state_d = S_WRITE_INV;
            S_WRITE_INV: if (last) state_d = S_READ_INV;
            S_READ_INV:  if (last) state_d = S_DONE;
`else
            S_READ:      if (last) state_d = S_DONE;
`endif
            S_DONE:      if (!start) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_st = 1'b0;
        rd_st = 1'b0;
        inv   = 1'b0;
        unique case (state_q)
            S_WRITE: wr_st = 1'b1;
            S_READ:  rd_st = 1'b1;
`ifdef DRAM_BIST_INV_PASS_EN
            S_WRITE_INV: begin
                wr_st = 1'b1;
                inv   = 1'b1;
            end
            S_READ_INV: begin
                rd_st = 1'b1;
                inv   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Address wraps to 0 on the last cell, so IDLE/DONE always see 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q         <= '0;
            lfsr_q         <= 8'h00;
            seed_q         <= 8'h00;
            err_count      <= 8'h00;
            first_err_addr <= '0;
            done_q         <= 1'b0;
        end else if (start_run) begin
            addr_q         <= '0;
            lfsr_q         <= seed_eff;
            seed_q         <= seed_eff;
            err_count      <= 8'h00;
            first_err_addr <= '0;
            done_q         <= 1'b0;
        end else begin
            if (wr_st || rd_st) begin
                addr_q <= addr_q + 1'b1;
                lfsr_q <= last ? seed_q : lfsr_nxt;
            end
            if (mismatch) begin
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'h01;
                end
                if (err_count == 8'h00) begin
                    first_err_addr <= addr_q;
                end
            end
            if (state_q == S_DONE) begin
                done_q <= 1'b1;
            end
        end
    end

    assign ram.ram_addr = addr_q;
    assign ram.ram_we   = wr_st;
    assign ram.ram_d    = wr_st & pat;

    assign busy = wr_st || rd_st || ((state_q == S_DONE) && !done_q);
    assign done = done_q;
    assign pass = done_q && (err_count == 8'h00);

endmodule

// File: tb/tb_dram_256x1_bist_ctrl.sv
// Directed bench for dram_256x1_bist_ctrl with a behavioural 256x1 RAM.
// Fault modes: 0 none, 1 flip 0x37/0x80, 2 invert all, 3 cell 0x10 stuck 0.
module tb_dram_256x1_bist_ctrl;

`ifdef DRAM_BIST_INV_PASS_EN
    localparam int ACTIVE = 1024;
    localparam int NPASS  = 2;
`else
    localparam int ACTIVE = 512;
    localparam int NPASS  = 1;
`endif
    localparam int DONE_E = ACTIVE + 1;
    localparam int LIMIT  = 1200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [7:0] first_err_addr;

    int checks = 0;
    int failures = 0;

    int fault_mode = 0;
    logic mem [256];

    logic wd [256];
    logic wd0 [256];
    int   we_err, busy_err, ovl, done_edge;

    dram_256x1_bist_ctrl_if #(.ADDR_W(8)) ram_if ();

    dram_256x1_bist_ctrl #(.ADDR_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .ram            (ram_if),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_d;
    end

    always_comb begin
        ram_if.ram_q = mem[ram_if.ram_addr];
        case (fault_mode)
            1: if (ram_if.ram_addr == 8'h37 || ram_if.ram_addr == 8'h80)
                   ram_if.ram_q = ~mem[ram_if.ram_addr];
            2: ram_if.ram_q = ~mem[ram_if.ram_addr];
            3: if (ram_if.ram_addr == 8'h10) ram_if.ram_q = 1'b0;
            default: ;
        endcase
    end

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    endfunction

    // Edge index e counts edges after E0; sampling happens #1 after each.
    task automatic run_bist(input logic [7:0] s, input int fm);
        fault_mode = fm;
        seed = s;
        we_err = 0;
        busy_err = 0;
        ovl = 0;
        done_edge = -1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 0; e < LIMIT; e++) begin
            if (e > 0) begin
                @(posedge clk);
                #1;
            end
            if (busy && done) ovl++;
            if (done) begin
                done_edge = e;
                break;
            end
            if (e < 256) wd[e] = ram_if.ram_d;
            if (ram_if.ram_we !== ((e < ACTIVE) && ((e % 512) < 256)))
                we_err++;
            if (e < ACTIVE && busy !== 1'b1) busy_err++;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ram_if.ram_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_we got=%b want=0", ram_if.ram_we);
        end
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {busy, done, pass});
        end
        checks++;
        if (err_count !== 8'h00 || first_err_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_counts got=%h/%h want=00/00",
                     err_count, first_err_addr);
        end
        checks++;
        if (ram_if.ram_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_addr got=%h want=00", ram_if.ram_addr);
        end
        #13 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] l;
        int diff;
        run_bist(8'h01, 0);
        checks++;
        if (done_edge !== DONE_E) begin
            failures++;
            $display("FAIL basic_done_edge got=%0d want=%0d", done_edge, DONE_E);
        end
        checks++;
        if (we_err !== 0) begin
            failures++;
            $display("FAIL basic_we_profile got=%0d bad want=0", we_err);
        end
        checks++;
        if (busy_err !== 0 || ovl !== 0) begin
            failures++;
            $display("FAIL basic_busy got=%0d/%0d want=0/0", busy_err, ovl);
        end
        checks++;
        if (pass !== 1'b1 || err_count !== 8'h00) begin
            failures++;
            $display("FAIL basic_pass got=%b/%h want=1/00", pass, err_count);
        end
        l = 8'h01;
        diff = 0;
        for (int i = 0; i < 256; i++) begin
            if (wd[i] !== l[0]) diff++;
            l = lfsr_step(l);
        end
        checks++;
        if (diff !== 0) begin
            failures++;
            $display("FAIL basic_pattern got=%0d diffs want=0", diff);
        end
        checks++;
        if (ram_if.ram_addr !== 8'h00) begin
            failures++;
            $display("FAIL done_addr got=%h want=00", ram_if.ram_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1) begin
            failures++;
            $display("FAIL result_hold got=%b%b%b want=110", done, pass, busy);
        end
    endtask

    task automatic test_seed_zero();
        int diff;
        for (int i = 0; i < 256; i++) wd0[i] = wd[i];
        run_bist(8'h00, 0);
        diff = 0;
        for (int i = 0; i < 256; i++) if (wd[i] !== wd0[i]) diff++;
        checks++;
        if (diff !== 0) begin
            failures++;
            $display("FAIL seed0_vs_seed1 got=%0d diffs want=0", diff);
        end
        checks++;
        if ({wd[0], wd[1], wd[2], wd[3]} !== 4'b1000) begin
            failures++;
            $display("FAIL seed0_first4 got=%b%b%b%b want=1000",
                     wd[0], wd[1], wd[2], wd[3]);
        end
    endtask

    task automatic test_two_faults();
        run_bist(8'hC3, 1);
        checks++;
        if (err_count !== 8'(2 * NPASS)) begin
            failures++;
            $display("FAIL two_err_count got=%0d want=%0d", err_count, 2 * NPASS);
        end
        checks++;
        if (first_err_addr !== 8'h37) begin
            failures++;
            $display("FAIL two_first_addr got=%h want=37", first_err_addr);
        end
        checks++;
        if (pass !== 1'b0 || done !== 1'b1) begin
            failures++;
            $display("FAIL two_pass got=%b/%b want=0/1", pass, done);
        end
    endtask

    task automatic test_invert_all();
        run_bist(8'h01, 2);
        checks++;
        if (err_count !== 8'hFF) begin
            failures++;
            $display("FAIL sat_err_count got=%0d want=255", err_count);
        end
        checks++;
        if (first_err_addr !== 8'h00) begin
            failures++;
            $display("FAIL sat_first_addr got=%h want=00", first_err_addr);
        end
        checks++;
        if (done_edge !== DONE_E) begin
            failures++;
            $display("FAIL sat_done_edge got=%0d want=%0d", done_edge, DONE_E);
        end
    endtask

    task automatic test_reset_midrun();
        fault_mode = 0;
        seed = 8'h33;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 99; i++) @(posedge clk);
        #2;
        checks++;
        if (ram_if.ram_we !== 1'b1 || ram_if.ram_addr !== 8'd99) begin
            failures++;
            $display("FAIL midrun_state got=%b/%0d want=1/99",
                     ram_if.ram_we, ram_if.ram_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ram_if.ram_we !== 1'b0 || ram_if.ram_addr !== 8'h00) begin
            failures++;
            $display("FAIL abort_bus got=%b/%h want=0/00",
                     ram_if.ram_we, ram_if.ram_addr);
        end
        checks++;
        if ({busy, done, pass} !== 3'b000 || err_count !== 8'h00) begin
            failures++;
            $display("FAIL abort_flags got=%b/%h want=000/00",
                     {busy, done, pass}, err_count);
        end
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ram_if.ram_we !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_restart got=%b/%b want=0/0",
                     busy, ram_if.ram_we);
        end
        run_bist(8'h5A, 0);
        checks++;
        if (pass !== 1'b1 || done_edge !== DONE_E) begin
            failures++;
            $display("FAIL rerun_5a got=%b/%0d want=1/%0d",
                     pass, done_edge, DONE_E);
        end
    endtask

    task automatic test_stuck_cell();
        logic [7:0] l;
        int exp_err;
        l = 8'h01;
        for (int i = 0; i < 16; i++) l = lfsr_step(l);
        exp_err = (NPASS == 2) ? 1 : int'(l[0]);
        run_bist(8'h01, 3);
        checks++;
        if (err_count !== 8'(exp_err)) begin
            failures++;
            $display("FAIL stuck_err_count got=%0d want=%0d", err_count, exp_err);
        end
        checks++;
        if (first_err_addr !== ((exp_err > 0) ? 8'h10 : 8'h00)) begin
            failures++;
            $display("FAIL stuck_first_addr got=%h want=%h", first_err_addr,
                     (exp_err > 0) ? 8'h10 : 8'h00);
        end
        checks++;
        if (done_edge !== DONE_E) begin
            failures++;
            $display("FAIL stuck_done_edge got=%0d want=%0d", done_edge, DONE_E);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;
        test_reset();
        test_basic();
        test_seed_zero();
        test_two_faults();
        test_invert_all();
        test_reset_midrun();
        test_stuck_cell();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
